ctrl_issue: RTL and testbench
=============================

# ctrl_issue

Upstream issue stage for the 7-input control decoder. Accepts control words with a repeat count over a valid/ready handshake, buffers them in a small FIFO, and drives exactly one registered 7-bit word per cycle onto the decoder inputs (out_op[i] feeds decoder input xi). Each word is held for (rep+1) consumed beats. The stage honours a downstream stall and drives NOP_CODE when it has nothing to issue.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- NOP_CODE, 7'h00: value driven on out_op whenever out_valid=0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  producer offers {in_op, in_rep}.
- in_ready  out  1  stage can accept; = (count < DEPTH) && rst_n; combinational.
- in_op  in  7  control word.
- in_rep  in  4  extra beats to hold word (0 = one beat, 15 = sixteen beats).
- stall  in  1  decoder side not consuming this cycle; freezes issue registers.
- out_op  out  7  registered word to decoder; bit i → xi.
- out_valid  out  1  out_op is a live word (registered).
- busy  out  1  out_valid || (count != 0).
- issued_cnt  out  16  consumed-beat counter, wraps mod 2^16.

## Operation
- Push: at an edge with in_valid && in_ready, write {in_op, in_rep} at wr_ptr; wr_ptr++ mod DEPTH.
- in_ready depends only on count at cycle start. When full, no push occurs even if a pop happens the same edge.
- Push while stall=1 is allowed.
- Pop and issue at each edge with stall=0:
  - ISSUE, rep_left != 0: rep_left--; out_op unchanged; out_valid stays 1.
  - ISSUE with rep_left == 0, or IDLE: if count != 0, pop head: out_op ← head.op, rep_left ← head.rep, out_valid ← 1, state ISSUE. Otherwise out_op ← NOP_CODE, out_valid ← 0, rep_left ← 0, state IDLE.
- stall=1: out_op, out_valid, rep_left, state and rd_ptr all hold. No pop. issued_cnt holds.
- States: IDLE (out_valid=0) and ISSUE (out_valid=1). State equals out_valid; there is no separate encoding.
- issued_cnt increments at every edge where out_valid=1 and stall=0 (one beat consumed).
- Count update: count ← count + push − pop. Both push and pop on the same edge is legal whenever 0 < count < DEPTH.
- A word written at an edge is not poppable until the next edge. There is no bypass.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_op=NOP_CODE, rep_left=0, count=0, both pointers 0, issued_cnt=0, state IDLE.
- in_ready=0 while rst_n=0.
- Reset mid-operation discards FIFO contents and any partially repeated word.
- Latency: push at edge N with stage idle and stall=0 → out_valid=1, out_op=word after edge N+1.
- Throughput: one word per cycle when every rep=0 and stall=0.
- A word with rep=r occupies exactly r+1 non-stalled cycles on out_op.
- Stall asserted during cycle k: outputs after edge k are identical to outputs before it.
- Pointers wrap at DEPTH. Full is count==DEPTH; empty is count==0.

## Test plan
- Reset, then push op=7'h15 rep=0 at edge 1 → out_valid=1, out_op=7'h15 after edge 2; out_valid=0, out_op=7'h00 after edge 3; issued_cnt=1.
- Push 7'h01 (rep 2), then 7'h02 (rep 0), no stall → out_op is 01,01,01,02 on four consecutive cycles, then NOP; issued_cnt=4.
- Hold stall=1 and push DEPTH=4 words → in_ready=0 after the 4th push; a 5th in_valid is not accepted. Release stall → the 4 words issue in FIFO order, and in_ready=1 after the first pop.
- Full FIFO with stall=0 and in_valid=1 on the same cycle as a pop → no push that edge, count=3; push is accepted on the next edge.
- Word 7'h7F rep=3 with stall pulsed in beats 2 and 3 → 7'h7F is visible for 6 cycles; issued_cnt advances by exactly 4.
- rst_n=0 for one edge while in ISSUE with 2 words queued → next cycle out_valid=0, out_op=NOP_CODE, busy=0, issued_cnt=0; queued words are never issued.

Source files
------------

// File: rtl/ctrl_issue.sv
// ctrl_issue
// Issue stage in front of the 7-input control decoder. Control words arrive
// with a repeat count over a valid/ready handshake, wait in a small FIFO, and
// are driven one registered word per consumed beat onto the decoder inputs.
// Each word stays on out_op for (rep+1) beats that the decoder consumes.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    producer offers {in_op, in_rep}
//   in_ready    stage can accept (combinational, from count only)
//   in_op       7-bit control word
//   in_rep      extra beats to hold the word
//   stall       decoder not consuming this cycle; freezes the issue side
//   out_op      registered word to decoder, bit i drives input xi
//   out_valid   out_op carries a live word
//   busy        a word is live or queued
//   issued_cnt  consumed-beat counter, wraps at 2^16
module ctrl_issue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [6:0]  NOP_CODE = 7'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_op,
  input  logic [3:0]  in_rep,
  input  logic        stall,
  output logic [6:0]  out_op,
  output logic        out_valid,
  output logic        busy,
  output logic [15:0] issued_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state;
  logic [6:0]      mem_op  [DEPTH];
  logic [3:0]      mem_rep [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [3:0]      rep_left;
  logic            do_push;
  logic            do_pop;
  logic            holding;

  // in_ready looks only at the occupancy at the start of the cycle, so a
  // full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign in_ready  = (count < CW'(DEPTH)) && rst_n;
  assign do_push   = in_valid && in_ready;
  assign holding   = (state == ISSUE) && (rep_left != 4'd0);
  assign do_pop    = !stall && !holding && (count != '0);
  assign out_valid = (state == ISSUE);
  assign busy      = out_valid || (count != '0);

  // Storage array needs no reset: the pointers and count are cleared, so
  // stale entries can never be popped.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_op[wr_ptr]  <= in_op;
      mem_rep[wr_ptr] <= in_rep;
    end
  end

  // Pointer/occupancy bookkeeping plus the IDLE/ISSUE machine. A stalled
  // cycle leaves every issue-side register untouched; pushes still land.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rep_left   <= 4'd0;
      out_op     <= NOP_CODE;
      state      <= IDLE;
      issued_cnt <= 16'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);

      if (!stall) begin
        if (state == ISSUE) issued_cnt <= issued_cnt + 16'd1;

        if (holding) begin
          rep_left <= rep_left - 4'd1;
        end else if (count != '0) begin
          out_op   <= mem_op[rd_ptr];
          rep_left <= mem_rep[rd_ptr];
          state    <= ISSUE;
        end else begin
          out_op   <= NOP_CODE;
          rep_left <= 4'd0;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_issue.sv
// tb_ctrl_issue
// Directed-vector bench for ctrl_issue (DEPTH=4, NOP_CODE=7'h00). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so every check sees the state produced by the preceding edge.
module tb_ctrl_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [3:0]  in_rep;
  logic        stall;
  logic [6:0]  out_op;
  logic        out_valid;
  logic        busy;
  logic [15:0] issued_cnt;

  int total = 0;
  int bad   = 0;

  ctrl_issue #(.DEPTH(4), .NOP_CODE(7'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rep     (in_rep),
    .stall      (stall),
    .out_op     (out_op),
    .out_valid  (out_valid),
    .busy       (busy),
    .issued_cnt (issued_cnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set producer/stall inputs for the next edge.
  task automatic applyStimulus(input logic v, input logic [6:0] op,
                               input logic [3:0] rep, input logic st);
    in_valid = v;
    in_op    = op;
    in_rep   = rep;
    stall    = st;
  endtask

  // Two reset edges with quiet inputs, then release.
  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Expect a live word on out_op.
  task automatic expectWord(input string tag, input logic [6:0] op);
    checkOutput({tag, ".valid"}, 16'(out_valid), 16'd1);
    checkOutput({tag, ".op"}, 16'(out_op), 16'(op));
  endtask

  // Expect the NOP code with nothing live.
  task automatic expectNop(input string tag);
    checkOutput({tag, ".valid"}, 16'(out_valid), 16'd0);
    checkOutput({tag, ".op"}, 16'(out_op), 16'h00);
  endtask

  logic [6:0] words [4];

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);

    // ---- reset state ----
    doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst.in_ready_low", 16'(in_ready), 16'd0);
    rst_n = 1'b1;
    #1;
    expectNop("rst");
    checkOutput("rst.busy", 16'(busy), 16'd0);
    checkOutput("rst.issued", issued_cnt, 16'd0);
    checkOutput("rst.in_ready", 16'(in_ready), 16'd1);

    // ---- single word, latency ----
    applyStimulus(1'b1, 7'h15, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    checkOutput("lat.not_yet", 16'(out_valid), 16'd0);
    checkOutput("lat.busy", 16'(busy), 16'd1);
    tick();
    expectWord("lat.e2", 7'h15);
    tick();
    expectNop("lat.e3");
    checkOutput("lat.issued", issued_cnt, 16'd1);

    // ---- repeat count: 01 x3 then 02 ----
    doReset();
    applyStimulus(1'b1, 7'h01, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 7'h02, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    expectWord("rep.b0", 7'h01);
    tick();
    expectWord("rep.b1", 7'h01);
    tick();
    expectWord("rep.b2", 7'h01);
    tick();
    expectWord("rep.b3", 7'h02);
    tick();
    expectNop("rep.end");
    checkOutput("rep.issued", issued_cnt, 16'd4);

    // ---- fill under stall, overflow refused, drain in order ----
    doReset();
    words[0] = 7'h11; words[1] = 7'h22; words[2] = 7'h33; words[3] = 7'h44;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, words[i], 4'd0, 1'b1);
      tick();
    end
    checkOutput("full.in_ready", 16'(in_ready), 16'd0);
    expectNop("full.stalled");
    applyStimulus(1'b1, 7'h55, 4'd0, 1'b1);
    tick();
    checkOutput("full.still_full", 16'(in_ready), 16'd0);
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    tick();
    checkOutput("full.ready_after_pop", 16'(in_ready), 16'd1);
    expectWord("full.w0", words[0]);
    for (int i = 1; i < 4; i++) begin
      tick();
      expectWord($sformatf("full.w%0d", i), words[i]);
    end
    tick();
    expectNop("full.drained");
    checkOutput("full.issued", issued_cnt, 16'd4);
    checkOutput("full.busy", 16'(busy), 16'd0);

    // ---- full FIFO with simultaneous pop: push deferred one edge ----
    doReset();
    words[0] = 7'h10; words[1] = 7'h11; words[2] = 7'h12; words[3] = 7'h13;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, words[i], 4'd0, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 7'h20, 4'd0, 1'b0);
    tick();
    expectWord("fp.w0", 7'h10);
    checkOutput("fp.ready_next", 16'(in_ready), 16'd1);
    tick();
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    expectWord("fp.w1", 7'h11);
    tick();
    expectWord("fp.w2", 7'h12);
    tick();
    expectWord("fp.w3", 7'h13);
    tick();
    expectWord("fp.late", 7'h20);
    tick();
    expectNop("fp.end");
    checkOutput("fp.issued", issued_cnt, 16'd5);

    // ---- stall inside a repeated word ----
    doReset();
    applyStimulus(1'b1, 7'h7F, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    tick();
    expectWord("st.c1", 7'h7F);
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b1);
    tick();
    expectWord("st.c2", 7'h7F);
    checkOutput("st.issued_frozen", issued_cnt, 16'd0);
    tick();
    expectWord("st.c3", 7'h7F);
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    for (int i = 4; i <= 6; i++) begin
      tick();
      expectWord($sformatf("st.c%0d", i), 7'h7F);
    end
    tick();
    expectNop("st.end");
    checkOutput("st.issued", issued_cnt, 16'd4);

    // ---- reset mid-issue discards queue ----
    doReset();
    applyStimulus(1'b1, 7'h41, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 7'h42, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 7'h43, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 7'h00, 4'd0, 1'b0);
    expectWord("mr.pre", 7'h41);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expectNop("mr.post");
    checkOutput("mr.busy", 16'(busy), 16'd0);
    checkOutput("mr.issued", issued_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectNop($sformatf("mr.quiet%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
